// File: rtl/present_encipher_iter.sv
// present_encipher_iter: iterative 16-bit-block / 20-bit-key PRESENT-style encryptor
// Latency: input accepted on edge T -> out_valid from the cycle after edge T+ROUNDS/UNROLL
// Backpressure: in_ready low while a block is in flight; out_valid/ctext held until out_ready
//
// File contents:
//    key_scheduler     - combinational expansion of the 20-bit key into round keys k0..k7
//    cipher_round_inv  - exact inverse of cipher_round(x,k) = P(S(x ^ k))
//    present_encipher_iter (top)
//
// Top ports:
//    clk, rst               single rising-edge clock, synchronous active-high reset
//    in_valid/in_ready      input handshake; ptext[15:0] and master_key[19:0] sampled on transfer
//    out_valid/out_ready    output handshake; ctext[15:0] registered and stable while stalled
//    busy                   high while a block is being processed or awaiting drain
//
// Build option: define PRESENT_ENC_EARLY_ACCEPT_EN to let DONE drain the result and accept
// a new block on the same edge (no IDLE bubble between back-to-back blocks).

// ---------------------------------------------------------------------------------------
// key_scheduler: K0 = key; K(i+1) = rotl7(Ki), top nibble through the S-box, bits [6:4]
// xored with the round number i+1. Round key ki = Ki[19:4].
//    i_key  20-bit master key (always the latched copy, never the live input)
//    o_rk   ki at o_rk[16*i +: 16], i = 0..7
// ---------------------------------------------------------------------------------------
module key_scheduler (
   input  logic [19:0]  i_key,
   output logic [127:0] o_rk
);

   function automatic logic [3:0] f_sbox(input logic [3:0] i_n);
      f_sbox = 4'h0;
      case (i_n)
         4'h0: f_sbox = 4'hC;
         4'h1: f_sbox = 4'h5;
         4'h2: f_sbox = 4'h6;
         4'h3: f_sbox = 4'hB;
         4'h4: f_sbox = 4'h9;
         4'h5: f_sbox = 4'h0;
         4'h6: f_sbox = 4'hA;
         4'h7: f_sbox = 4'hD;
         4'h8: f_sbox = 4'h3;
         4'h9: f_sbox = 4'hE;
         4'hA: f_sbox = 4'hF;
         4'hB: f_sbox = 4'h8;
         4'hC: f_sbox = 4'h4;
         4'hD: f_sbox = 4'h7;
         4'hE: f_sbox = 4'h1;
         4'hF: f_sbox = 4'h2;
         default: f_sbox = 4'h0;
      endcase
   endfunction

   // Full 20-bit key state for K0..K6; K7 is only needed for its top 16 bits.
   logic [19:0] w_kr [0:6];

   assign w_kr[0] = i_key;

   // rotl7 written as a direct bit regroup:
   //   rot[19:16]=K[12:9], rot[15:7]=K[8:0], rot[6:4]=K[19:17], rot[3:0]=K[16:13]
   for (genvar g = 1; g < 7; g++) begin : g_upd
      assign w_kr[g] = {f_sbox(w_kr[g-1][12:9]), w_kr[g-1][8:0],
                        w_kr[g-1][19:17] ^ 3'(g), w_kr[g-1][16:13]};
   end

   for (genvar g = 0; g < 7; g++) begin : g_out
      assign o_rk[16*g +: 16] = w_kr[g][19:4];
   end

   assign o_rk[127:112] = {f_sbox(w_kr[6][12:9]), w_kr[6][8:0], w_kr[6][19:17] ^ 3'd7};

endmodule

// ---------------------------------------------------------------------------------------
// cipher_round_inv: inverse of cipher_round(x,k) = P(S(x ^ k)).
// The forward bit layer moves bit i to (4*i) mod 15 (bit 15 stays), so the inverse reads
// output bit i from input bit (4*i) mod 15, then applies the inverse S-box and the key.
//    i_x  16-bit state in
//    i_k  16-bit round key
//    o_y  16-bit state out
// ---------------------------------------------------------------------------------------
module cipher_round_inv (
   input  logic [15:0] i_x,
   input  logic [15:0] i_k,
   output logic [15:0] o_y
);

   function automatic logic [3:0] f_sbox_inv(input logic [3:0] i_n);
      f_sbox_inv = 4'h0;
      case (i_n)
         4'h0: f_sbox_inv = 4'h5;
         4'h1: f_sbox_inv = 4'hE;
         4'h2: f_sbox_inv = 4'hF;
         4'h3: f_sbox_inv = 4'h8;
         4'h4: f_sbox_inv = 4'hC;
         4'h5: f_sbox_inv = 4'h1;
         4'h6: f_sbox_inv = 4'h2;
         4'h7: f_sbox_inv = 4'hD;
         4'h8: f_sbox_inv = 4'hB;
         4'h9: f_sbox_inv = 4'h4;
         4'hA: f_sbox_inv = 4'h6;
         4'hB: f_sbox_inv = 4'h3;
         4'hC: f_sbox_inv = 4'h0;
         4'hD: f_sbox_inv = 4'h7;
         4'hE: f_sbox_inv = 4'h9;
         4'hF: f_sbox_inv = 4'hA;
         default: f_sbox_inv = 4'h0;
      endcase
   endfunction

   logic [15:0] w_p;

   for (genvar g = 0; g < 15; g++) begin : g_perm
      assign w_p[g] = i_x[(4*g) % 15];
   end
   assign w_p[15] = i_x[15];

   for (genvar n = 0; n < 4; n++) begin : g_sub
      assign o_y[4*n +: 4] = f_sbox_inv(w_p[4*n +: 4]) ^ i_k[4*n +: 4];
   end

endmodule

// ---------------------------------------------------------------------------------------
// present_encipher_iter (top)
//    x0 = ptext ^ k0; xi = cipher_round_inv(x(i-1), ki), i = 1..7; ctext = x7.
//    UNROLL rounds are evaluated per clock (1 or 7).
// ---------------------------------------------------------------------------------------
module present_encipher_iter #(
   parameter int ROUNDS = 7,
   parameter int UNROLL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] ptext,
   input  logic [19:0] master_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] ctext,
   output logic        busy
);

   if (ROUNDS != 7) begin : g_bad_rounds
      $error("present_encipher_iter: ROUNDS must be 7");
   end
   if (UNROLL != 1 && UNROLL != 7) begin : g_bad_unroll
      $error("present_encipher_iter: UNROLL must be 1 or 7");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_fsm;
   logic [15:0]  r_state;
   logic [19:0]  r_key;
   logic [2:0]   r_rnd;

   logic [127:0] w_rk;
   logic [15:0]  w_chain [0:UNROLL];
   logic [3:0]   w_last_rnd;
   logic         w_last;
   logic         w_accept;

   // Round keys always come from the latched key, so input changes after
   // acceptance cannot disturb the block in flight.
   key_scheduler u_ks (
      .i_key (r_key),
      .o_rk  (w_rk)
   );

   assign w_chain[0] = r_state;

   // Stage g applies round r_rnd+g. In legal configurations the index never
   // exceeds 7 while in RUN, so the 3-bit sum does not wrap.
   for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
      logic [2:0]  w_idx;
      logic [15:0] w_k;

      assign w_idx = r_rnd + 3'(g);
      assign w_k   = w_rk[{w_idx, 4'b0000} +: 16];

      cipher_round_inv u_rnd (
         .i_x (w_chain[g]),
         .i_k (w_k),
         .o_y (w_chain[g+1])
      );
   end

   // This step is the final one when its highest round reaches ROUNDS.
   assign w_last_rnd = {1'b0, r_rnd} + 4'(UNROLL - 1);
   assign w_last     = (w_last_rnd >= 4'(ROUNDS));

   // in_ready is forced low during reset so nothing is taken in the reset cycle.
   always_comb begin
      in_ready = 1'b0;
      case (r_fsm)
         S_IDLE:  in_ready = 1'b1;
`ifdef PRESENT_ENC_EARLY_ACCEPT_EN
         S_DONE:  in_ready = out_ready;
`endif
         default: in_ready = 1'b0;
      endcase
      if (rst) begin
         in_ready = 1'b0;
      end
   end

   assign w_accept = in_valid & in_ready;
   assign busy     = (r_fsm != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm     <= S_IDLE;
         out_valid <= 1'b0;
         ctext     <= 16'h0000;
         r_state   <= 16'h0000;
         r_key     <= 20'h00000;
         r_rnd     <= 3'd0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
            end
            S_RUN: begin
               r_state <= w_chain[UNROLL];
               if (w_last) begin
                  ctext     <= w_chain[UNROLL];
                  out_valid <= 1'b1;
                  r_fsm     <= S_DONE;
               end else begin
                  r_rnd <= r_rnd + 3'(UNROLL);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_fsm     <= S_IDLE;
               end
            end
            default: r_fsm <= S_IDLE;
         endcase

         // Acceptance is evaluated last so that, when early accept is built in,
         // a same-edge drain+accept ends up in RUN rather than IDLE.
         if (w_accept) begin
            r_key   <= master_key;
            r_state <= ptext ^ master_key[19:4];
            r_rnd   <= 3'd1;
            r_fsm   <= S_RUN;
         end
      end
   end

endmodule
